// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the VeriRISC sequential ALU.
//   - 4-bit opcode encodings (0-7 keep their legacy meaning)
//   - FSM state type used by alu_seq
package alu_pkg;

  localparam logic [3:0] OP_HLT = 4'd0;
  localparam logic [3:0] OP_SKZ = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LDA = 4'd5;
  localparam logic [3:0] OP_STO = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_SUB = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_FINISH  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier datapath.
//   clk, rst_n    : clock, synchronous active-low reset
//   load          : capture operands, clear accumulator, count = DATA_WIDTH
//   step          : one shift-add iteration
//   mcand_in      : multiplicand (operand A)
//   mplier_in     : multiplier (operand B)
//   last          : all iterations done (count is zero)
//   product       : full 2*DATA_WIDTH-bit accumulator
module alu_mul_iter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      step,
  input  logic [DATA_WIDTH-1:0]     mcand_in,
  input  logic [DATA_WIDTH-1:0]     mplier_in,
  output logic                      last,
  output logic [2*DATA_WIDTH-1:0]   product
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = {{DATA_WIDTH{1'b0}}, mcand_in};
      mplier_d = mplier_in;
      acc_d    = '0;
      cnt_d    = CW'(DATA_WIDTH);
    end else if (step) begin
      // Multiplicand shifts left in step with the multiplier shifting right,
      // so each multiplier bit adds the correctly weighted partial product.
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign last    = (cnt_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: VeriRISC ALU with registered result and start/done handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : accept an operation when not busy
//   opcode     : operation select (sampled with start)
//   in_a, in_b : operands (sampled with start)
//   alu_out    : registered result, held until next done
//   carry      : carry / borrow / shifted-out bit / MUL overflow
//   zero       : alu_out == 0
//   busy       : multi-cycle MUL in progress, start ignored
//   done       : one-cycle pulse, result and flags valid
//   a_is_zero  : combinational in_a == 0
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  output logic [DATA_WIDTH-1:0]   alu_out,
  output logic                    carry,
  output logic                    zero,
  output logic                    busy,
  output logic                    done,
  output logic                    a_is_zero
);

  alu_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   alu_out_q, alu_out_d;
  logic                    carry_q, carry_d;
  logic                    zero_q, zero_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [DATA_WIDTH-1:0]   sc_res;
  logic                    sc_carry;
  logic                    mul_load, mul_step, mul_last;
  logic [2*DATA_WIDTH-1:0] mul_prod;

  alu_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (mul_load),
    .step      (mul_step),
    .mcand_in  (in_a),
    .mplier_in (in_b),
    .last      (mul_last),
    .product   (mul_prod)
  );

  // Single-cycle datapath
  always_comb begin
    sc_res   = in_a;
    sc_carry = 1'b0;
    case (opcode)
      OP_ADD: {sc_carry, sc_res} = {1'b0, in_a} + {1'b0, in_b};
      OP_AND: sc_res = in_a & in_b;
      OP_XOR: sc_res = in_a ^ in_b;
      OP_LDA: sc_res = in_b;
      OP_SUB: begin
        sc_res   = in_a - in_b;
        sc_carry = (in_a < in_b);
      end
      OP_OR:  sc_res = in_a | in_b;
      OP_SHL: begin
        sc_res   = {in_a[DATA_WIDTH-2:0], 1'b0};
        sc_carry = in_a[DATA_WIDTH-1];
      end
      OP_SHR: begin
        sc_res   = {1'b0, in_a[DATA_WIDTH-1:1]};
        sc_carry = in_a[0];
      end
      default: sc_res = in_a;
    endcase
  end

  // Next-state / output-register logic
  always_comb begin
    state_d   = state_q;
    alu_out_d = alu_out_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mul_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (opcode == OP_MUL) begin
            mul_load = 1'b1;
            busy_d   = 1'b1;
            state_d  = ST_MUL_RUN;
          end else begin
            alu_out_d = sc_res;
            carry_d   = sc_carry;
            zero_d    = (sc_res == '0);
            done_d    = 1'b1;
          end
        end
      end
      // The count is checked before stepping, so MUL_RUN spends one extra
      // cycle after the final iteration; this gives DATA_WIDTH+2 latency.
      ST_MUL_RUN: begin
        if (mul_last) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        alu_out_d = mul_prod[DATA_WIDTH-1:0];
        carry_d   = |mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        zero_d    = (mul_prod[DATA_WIDTH-1:0] == '0);
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mul_step = (state_q == ST_MUL_RUN) && !mul_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      alu_out_q <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign alu_out   = alu_out_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign a_is_zero = (in_a == '0);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq with a behavioural
// arithmetic reference model and randomized operations.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   opcode;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] alu_out;
  logic         carry, zero, busy, done, a_is_zero;

  int errors = 0;
  int checks = 0;

  alu_seq #(.DATA_WIDTH(W), .OPCODE_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .in_a      (in_a),
    .in_b      (in_b),
    .alu_out   (alu_out),
    .carry     (carry),
    .zero      (zero),
    .busy      (busy),
    .done      (done),
    .a_is_zero (a_is_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {carry, result} from plain integer arithmetic.
  function automatic logic [W:0] ref_op(input int op, input int a, input int b);
    int m, r, c;
    m = 1 << W;
    c = 0;
    case (op)
      2:  begin r = a + b; c = (r >= m) ? 1 : 0; end
      3:  r = a & b;
      4:  r = a ^ b;
      5:  r = b;
      8:  begin r = a - b + m; c = (a < b) ? 1 : 0; end
      9:  r = a | b;
      10: begin r = a * 2; c = (a >= m / 2) ? 1 : 0; end
      11: begin r = a / 2; c = a % 2; end
      12: begin r = a * b; c = (r >= m) ? 1 : 0; end
      default: r = a;
    endcase
    r = r % m;
    return {c[0], r[W-1:0]};
  endfunction

  task automatic check_result(input string tag, input int op, input int a, input int b);
    logic [W:0] e;
    e = ref_op(op, a, b);
    check({tag, "_out"},   32'(alu_out), 32'(e[W-1:0]));
    check({tag, "_carry"}, 32'(carry),   32'(e[W]));
    check({tag, "_zero"},  32'(zero),    32'(e[W-1:0] == '0));
  endtask

  // Single-cycle op; leaves start low. Called back-to-back it issues
  // starts on consecutive edges.
  task automatic do_single(input string tag, input int op, input int a, input int b);
    start = 1'b1; opcode = 4'(op); in_a = W'(a); in_b = W'(b);
    @(posedge clk); #1;
    start = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check_result(tag, op, a, b);
  endtask

  // MUL; optionally pulse an ignored ADD start at cycle ign_at (0 = none).
  task automatic do_mul(input string tag, input int a, input int b, input int ign_at);
    int n;
    int ndone;
    start = 1'b1; opcode = 4'd12; in_a = W'(a); in_b = W'(b);
    @(posedge clk); #1;
    start = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom);
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    n = 0;
    ndone = 0;
    while (n < 20 && ndone == 0) begin
      if (n + 1 == ign_at) begin
        start = 1'b1; opcode = 4'd2; in_a = 8'd1; in_b = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (done) ndone = 1;
    end
    check({tag, "_latency"}, 32'(n), 32'd10);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_result(tag, 12, a, b);
  endtask

  initial begin
    logic [W:0] e;
    int ndone;
    rst_n = 1'b0; start = 1'b0; opcode = '0; in_a = '0; in_b = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out",   32'(alu_out), 32'd0);
    check("rst_zero",  32'(zero),    32'd1);
    check("rst_carry", 32'(carry),   32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_done",  32'(done),    32'd0);
    check("rst_azero", 32'(a_is_zero), 32'd1);
    rst_n = 1'b1;

    // Directed
    do_single("add", 2, 'hF0, 'h20);
    do_single("sub_eq", 8, 'h05, 'h05);
    do_single("sub_bor", 8, 'h03, 'h04);
    do_single("shl", 10, 'h81, 0);
    do_single("shr", 11, 'h81, 0);
    @(posedge clk); #1;
    check("idle_done", 32'(done), 32'd0);
    e = ref_op(11, 'h81, 0);
    check("hold_out", 32'(alu_out), 32'(e[W-1:0]));

    do_mul("mul1", 13, 11, 0);
    do_mul("mul_ovf", 'h10, 'h10, 0);
    do_mul("mul_ign", 200, 3, 4);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("ign_one_done", 32'(ndone), 32'd0);
    check_result("ign_hold", 12, 200, 3);

    // Legacy opcodes
    do_single("hlt", 0, 'h3C, 'hA5);
    do_single("skz", 1, 'h3C, 'hA5);
    do_single("lda", 5, 'h3C, 'hA5);
    do_single("sto", 6, 'h3C, 'hA5);
    do_single("jmp", 7, 'h3C, 'hA5);
    do_single("op15", 15, 'h3C, 'hA5);

    in_a = '0; #1;
    check("azero_1", 32'(a_is_zero), 32'd1);
    in_a = 8'h40; #1;
    check("azero_0", 32'(a_is_zero), 32'd0);

    // MUL immediately followed by a start in its done cycle
    do_mul("mul_b2b", 7, 9, 0);
    do_single("after_mul", 4, 'h55, 'h0F);

    // Random mix
    for (int i = 0; i < 40; i++) begin
      int op, a, b;
      op = int'($urandom_range(0, 15));
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      if (i % 7 == 0) a = 0;
      if (op == 12) do_mul("rnd_mul", a, b, int'($urandom_range(0, 6)));
      else          do_single("rnd", op, a, b);
    end

    // Reset mid-MUL
    start = 1'b1; opcode = 4'd12; in_a = 8'd99; in_b = 8'd77;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mrst_busy",  32'(busy),    32'd0);
    check("mrst_done",  32'(done),    32'd0);
    check("mrst_out",   32'(alu_out), 32'd0);
    check("mrst_zero",  32'(zero),    32'd1);
    check("mrst_carry", 32'(carry),   32'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("mrst_no_done", 32'(ndone), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
